note_judge: RTL and testbench
=============================

Name: note_judge

Overview:
- Scoring stage downstream of the steady-mode player.
- Compares each player hit (octave/note/length from the hit decoder) against the current song goal (octave/note/length from the song ROM).
- Issues a per-note verdict and accumulates score, combo and best combo, then grades the run when the song ends.
- Outputs drive the score display and result LEDs.

Parameters:
- OCT_W, 3, octave field width
- NOTE_W, 3, note field width (0 = rest)
- LEN_W, 3, length field width
- SCORE_W, 12, score/total width
- COMBO_W, 8, combo counter width
- PERF_PTS, 3, points for PERFECT
- GOOD_PTS, 1, points for GOOD

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  mode enable; low forces IDLE, holds results
- start  in  1  one-cycle pulse; clears results and begins a run (honoured in IDLE only)
- hit_valid  in  1  one-cycle pulse per completed player hit
- hit_octave  in  OCT_W  player octave
- hit_note  in  NOTE_W  player note
- hit_length  in  LEN_W  player length
- goal_octave  in  OCT_W  current song octave
- goal_note  in  NOTE_W  current song note
- goal_length  in  LEN_W  current song length
- note_adv  in  1  one-cycle pulse; song index advanced to next note
- song_end  in  1  level; song index past last note
- judge_valid  out  1  one-cycle verdict strobe
- judge_result  out  2  00 none, 01 MISS, 10 GOOD, 11 PERFECT; held until next verdict
- score  out  SCORE_W  accumulated points, saturating
- combo  out  COMBO_W  consecutive non-MISS count, saturating
- max_combo  out  COMBO_W  best combo this run
- grade  out  2  00 C, 01 B, 10 A, 11 S; valid when done=1
- done  out  1  run finished, results frozen

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; internal goal latch 0; total_notes 0; judged flag 0.
- States: IDLE, WAIT, JUDGE, FINISH.
- IDLE
  - start=1 with en=1: clear score, combo, max_combo, judge_result, grade, done, total_notes.
  - Latch the goal_* fields, clear judged, go to WAIT.
- WAIT
  - hit_valid and not judged: register the hit fields, set judged, go to JUDGE.
  - hit_valid with judged=1: ignored; no verdict, no score change.
  - note_adv and judged=0: MISS verdict issued in the next cycle (judge_valid=1, result 01, combo←0); total_notes+1; relatch goal; judged←0.
  - note_adv and judged=1: total_notes+1; relatch goal; judged←0.
  - Same cycle hit_valid and note_adv, judged=0:
    - The hit is judged against the old latched goal (no MISS).
    - total_notes+1, goal relatched from the new goal_*, judged←0 for the new note.
  - song_end=1: go to FINISH; takes precedence over hit_valid and note_adv that cycle.
- JUDGE (exactly one cycle)
  - PERFECT: octave, note and length all equal.
  - GOOD: octave and note equal, length differs.
  - MISS: otherwise.
  - Registered outputs update at the end of this cycle, so judge_valid is high in the cycle after JUDGE. Latency from the hit_valid edge to judge_valid is 2 cycles.
  - PERFECT adds PERF_PTS, GOOD adds GOOD_PTS; score saturates at all-ones.
  - Non-MISS: combo+1, saturating. MISS: combo←0.
  - max_combo←max(max_combo, new combo).
  - A note_adv arriving during JUDGE is captured and processed on return to WAIT; it is never dropped.
  - Return to WAIT.
- FINISH
  - One cycle to compute the grade, with max = 3·total_notes (shift+add, SCORE_W+2 bits):
    - S: score == max and total_notes > 0
    - A: 4·score ≥ 3·max
    - B: 2·score ≥ max
    - C: otherwise
    - total_notes = 0 → C.
  - Then done=1; hold all results.
  - start pulse re-enters a run via the IDLE clear path.
- en=0 in any state: synchronously go to IDLE.
  - judge_valid←0; score, combo, max_combo, grade and done hold.
  - Inputs ignored until en=1 and start.
- judge_valid is never high for two consecutive cycles on the same note.

Test Plan:
- Reset mid-run with score=7 → all outputs 0, state IDLE, next start required.
- start; 3 notes each hit exactly (oct 4, note 5, len 2) then note_adv; song_end → score=9, combo=3, max_combo=3, grade=S, done=1.
- start; hit with length wrong, then note_adv, then no hit and note_adv → verdicts GOOD then MISS; score=1, combo=0, max_combo=1, total=2, grade=C.
- hit_valid and note_adv in the same cycle with the old goal matching → PERFECT against the old goal; no MISS; next note fresh.
- Two hit_valid pulses on one note → a single verdict; score +3 only once.
- 300 consecutive PERFECTs with COMBO_W=8 → combo and max_combo saturate at 255; score=900.

Source files
------------

// File: rtl/note_judge.sv
// note_judge: grades player hits against the song goal, keeping score, combo and a final grade.
module note_judge #(
   parameter int OCT_W    = 3,
   parameter int NOTE_W   = 3,
   parameter int LEN_W    = 3,
   parameter int SCORE_W  = 12,
   parameter int COMBO_W  = 8,
   parameter int PERF_PTS = 3,
   parameter int GOOD_PTS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               start,
   input  logic               hit_valid,
   input  logic [OCT_W-1:0]   hit_octave,
   input  logic [NOTE_W-1:0]  hit_note,
   input  logic [LEN_W-1:0]   hit_length,
   input  logic [OCT_W-1:0]   goal_octave,
   input  logic [NOTE_W-1:0]  goal_note,
   input  logic [LEN_W-1:0]   goal_length,
   input  logic               note_adv,
   input  logic               song_end,
   output logic               judge_valid,
   output logic [1:0]         judge_result,
   output logic [SCORE_W-1:0] score,
   output logic [COMBO_W-1:0] combo,
   output logic [COMBO_W-1:0] max_combo,
   output logic [1:0]         grade,
   output logic               done
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, JUDGE = 2'd2, FINISH = 2'd3;
   logic [1:0]         state;
   logic [OCT_W-1:0]   g_oct, h_oct;
   logic [NOTE_W-1:0]  g_note, h_note;
   logic [LEN_W-1:0]   g_len, h_len;
   logic               judged, adv_pend, adv;
   logic [SCORE_W-1:0] total, new_score;
   logic [SCORE_W:0]   sum;
   logic [COMBO_W-1:0] new_combo;
   logic [1:0]         verdict, grade_next;
   logic [SCORE_W+3:0] tot_w, sc_w, mx;
   always_comb begin
      adv        = note_adv | adv_pend;
      verdict    = (h_oct == g_oct && h_note == g_note) ? ((h_len == g_len) ? 2'b11 : 2'b10) : 2'b01;
      sum        = {1'b0, score} + ((verdict == 2'b11) ? (SCORE_W+1)'(PERF_PTS) :
                                    (verdict == 2'b10) ? (SCORE_W+1)'(GOOD_PTS) : '0);
      new_score  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      new_combo  = (verdict == 2'b01) ? '0 : (&combo) ? combo : combo + 1'b1;
      tot_w      = (SCORE_W+4)'(total);
      sc_w       = (SCORE_W+4)'(score);
      mx         = (tot_w << 1) + tot_w;
      grade_next = (total == '0) ? 2'd0 :
                   (sc_w == mx) ? 2'd3 :
                   ((sc_w << 2) >= (mx << 1) + mx) ? 2'd2 :
                   ((sc_w << 1) >= mx) ? 2'd1 : 2'd0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         g_oct        <= '0;
         g_note       <= '0;
         g_len        <= '0;
         h_oct        <= '0;
         h_note       <= '0;
         h_len        <= '0;
         judged       <= 1'b0;
         adv_pend     <= 1'b0;
         total        <= '0;
         judge_valid  <= 1'b0;
         judge_result <= '0;
         score        <= '0;
         combo        <= '0;
         max_combo    <= '0;
         grade        <= '0;
         done         <= 1'b0;
      end else if (!en) begin
         state       <= IDLE;
         judge_valid <= 1'b0;
         adv_pend    <= 1'b0;
      end else begin
         judge_valid <= 1'b0;
         case (state)
            IDLE: if (start) begin
               score        <= '0;
               combo        <= '0;
               max_combo    <= '0;
               judge_result <= '0;
               grade        <= '0;
               done         <= 1'b0;
               total        <= '0;
               g_oct        <= goal_octave;
               g_note       <= goal_note;
               g_len        <= goal_length;
               judged       <= 1'b0;
               adv_pend     <= 1'b0;
               state        <= WAIT;
            end
            WAIT: if (song_end) begin
               state <= FINISH;
            end else if (hit_valid && !judged) begin
               // A simultaneous advance is deferred so the hit is judged against the old goal
               h_oct    <= hit_octave;
               h_note   <= hit_note;
               h_len    <= hit_length;
               judged   <= 1'b1;
               adv_pend <= note_adv;
               state    <= JUDGE;
            end else if (adv) begin
               total    <= total + 1'b1;
               g_oct    <= goal_octave;
               g_note   <= goal_note;
               g_len    <= goal_length;
               judged   <= 1'b0;
               adv_pend <= 1'b0;
               if (!judged) begin
                  judge_valid  <= 1'b1;
                  judge_result <= 2'b01;
                  combo        <= '0;
               end
            end
            JUDGE: begin
               judge_valid  <= 1'b1;
               judge_result <= verdict;
               score        <= new_score;
               combo        <= new_combo;
               max_combo    <= (new_combo > max_combo) ? new_combo : max_combo;
               if (note_adv) adv_pend <= 1'b1;
               state        <= WAIT;
            end
            default: begin
               grade <= grade_next;
               done  <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: directed and randomized note sequences checked against a rule-level scoring model.
module tb_note_judge;
   logic       clk = 1'b0, rst = 1'b1, en = 1'b1, start = 1'b0, hit_valid = 1'b0;
   logic [2:0] hit_octave = '0, hit_note = '0, hit_length = '0;
   logic [2:0] goal_octave = '0, goal_note = '0, goal_length = '0;
   logic       note_adv = 1'b0, song_end = 1'b0;
   logic       judge_valid, done;
   logic [1:0] judge_result, grade;
   logic [11:0] score;
   logic [7:0] combo, max_combo;
   int tests = 0, fails = 0;
   int m_score, m_combo, m_max, m_total;
   int g_o, g_n, g_l;
   bit fix_goal = 1'b0;

   note_judge dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .hit_valid(hit_valid),
      .hit_octave(hit_octave), .hit_note(hit_note), .hit_length(hit_length),
      .goal_octave(goal_octave), .goal_note(goal_note), .goal_length(goal_length),
      .note_adv(note_adv), .song_end(song_end), .judge_valid(judge_valid),
      .judge_result(judge_result), .score(score), .combo(combo), .max_combo(max_combo),
      .grade(grade), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_goal(input int o, input int n, input int l);
      g_o = o; g_n = n; g_l = l;
      goal_octave = 3'(o); goal_note = 3'(n); goal_length = 3'(l);
   endtask

   task automatic apply(input int v);
      int pts;
      pts = (v == 3) ? 3 : (v == 2) ? 1 : 0;
      m_score = (m_score + pts > 4095) ? 4095 : m_score + pts;
      m_combo = (v == 1) ? 0 : (m_combo == 255) ? 255 : m_combo + 1;
      if (m_combo > m_max) m_max = m_combo;
   endtask

   task automatic start_run(input int o, input int n, input int l);
      set_goal(o, n, l);
      start = 1'b1;
      tick();
      start = 1'b0;
      m_score = 0; m_combo = 0; m_max = 0; m_total = 0;
      chk("start_score", 32'(score), 0);
      chk("start_done", 32'(done), 0);
   endtask

   // kind: 0 no hit, 1 exact hit, 2 length wrong, 3 pitch wrong
   task automatic do_note(input int kind, input bit dbl, input bit same);
      int no, nn, nl, ho, hn, hl, v;
      no = fix_goal ? g_o : int'($urandom_range(0, 7));
      nn = fix_goal ? g_n : int'($urandom_range(1, 7));
      nl = fix_goal ? g_l : int'($urandom_range(0, 7));
      if (kind != 0) begin
         ho = g_o; hn = g_n; hl = g_l;
         if (kind == 2) hl = (g_l + 1) % 8;
         if (kind == 3) begin
            if ($urandom_range(0, 1) == 1) ho = (g_o + 1) % 8; else hn = (g_n + 1) % 8;
            hl = int'($urandom_range(0, 7));
         end
         v = (ho == g_o && hn == g_n) ? ((hl == g_l) ? 3 : 2) : 1;
         hit_octave = 3'(ho); hit_note = 3'(hn); hit_length = 3'(hl);
         hit_valid = 1'b1;
         if (same) begin
            note_adv = 1'b1;
            set_goal(no, nn, nl);
         end
         tick();
         hit_valid = 1'b0; note_adv = 1'b0;
         chk("jv_early", 32'(judge_valid), 0);
         tick();
         apply(v);
         chk("jv_hit", 32'(judge_valid), 1);
         chk("verdict", 32'(judge_result), 32'(v));
         chk("score", 32'(score), 32'(m_score));
         chk("max_combo", 32'(max_combo), 32'(m_max));
         if (same) begin
            m_total++;
            tick();
            chk("same_no_miss", 32'(judge_valid), 0);
            chk("same_combo", 32'(combo), 32'(m_combo));
            return;
         end
         if (dbl) begin
            hit_valid = 1'b1;
            tick();
            hit_valid = 1'b0;
            tick();
            chk("dbl_no_verdict", 32'(judge_valid), 0);
            chk("dbl_score", 32'(score), 32'(m_score));
         end
      end
      note_adv = 1'b1;
      set_goal(no, nn, nl);
      tick();
      note_adv = 1'b0;
      m_total++;
      if (kind == 0) begin
         m_combo = 0;
         chk("miss_jv", 32'(judge_valid), 1);
         chk("miss_res", 32'(judge_result), 1);
      end else begin
         chk("adv_no_jv", 32'(judge_valid), 0);
      end
      chk("combo", 32'(combo), 32'(m_combo));
   endtask

   task automatic finish_song();
      int mx, eg;
      song_end = 1'b1;
      tick();
      song_end = 1'b0;
      for (int i = 0; i < 5 && !done; i++) tick();
      chk("done", 32'(done), 1);
      mx = 3 * m_total;
      eg = (m_total == 0) ? 0 : (m_score == mx) ? 3 : (4 * m_score >= 3 * mx) ? 2 :
           (2 * m_score >= mx) ? 1 : 0;
      chk("grade", 32'(grade), 32'(eg));
      chk("final_score", 32'(score), 32'(m_score));
      chk("final_combo", 32'(combo), 32'(m_combo));
      chk("final_max", 32'(max_combo), 32'(m_max));
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      chk("rst_score", 32'(score), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_jr", 32'(judge_result), 0);
      // reset mid-run after reaching score 7
      start_run(1, 2, 3);
      do_note(1, 0, 0); do_note(1, 0, 0); do_note(2, 0, 0);
      chk("pre_rst_score", 32'(score), 7);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_score", 32'(score), 0);
      chk("async_combo", 32'(combo), 0);
      chk("async_max", 32'(max_combo), 0);
      chk("async_jr", 32'(judge_result), 0);
      @(negedge clk);
      rst = 1'b0;
      hit_octave = 3'(g_o); hit_note = 3'(g_n); hit_length = 3'(g_l);
      hit_valid = 1'b1;
      tick();
      hit_valid = 1'b0;
      tick();
      chk("idle_ignores_hit", 32'(judge_valid), 0);
      chk("idle_score", 32'(score), 0);
      // three exact notes
      fix_goal = 1'b1;
      start_run(4, 5, 2);
      for (int i = 0; i < 3; i++) do_note(1, 0, 0);
      finish_song();
      chk("s_grade", 32'(grade), 3);
      fix_goal = 1'b0;
      // GOOD then MISS
      start_run(2, 3, 4);
      do_note(2, 0, 0); do_note(0, 0, 0);
      finish_song();
      chk("c_grade", 32'(grade), 0);
      // same-cycle hit and advance, then double hit
      start_run(6, 1, 5);
      do_note(1, 0, 1); do_note(1, 0, 0); do_note(1, 1, 0); do_note(3, 0, 1);
      finish_song();
      // combo saturation
      fix_goal = 1'b1;
      start_run(3, 3, 3);
      for (int i = 0; i < 300; i++) do_note(1, 0, 0);
      finish_song();
      chk("sat_combo", 32'(combo), 255);
      chk("sat_score", 32'(score), 900);
      fix_goal = 1'b0;
      // randomized run
      start_run(int'($urandom_range(0, 7)), int'($urandom_range(1, 7)), int'($urandom_range(0, 7)));
      for (int i = 0; i < 60; i++) begin
         int k;
         k = int'($urandom_range(0, 3));
         do_note(k, 1'($urandom_range(0, 1)), (k != 0) && ($urandom_range(0, 3) == 0));
      end
      finish_song();
      // disabling holds the results
      en = 1'b0;
      tick(); tick();
      chk("en_jv", 32'(judge_valid), 0);
      chk("en_done", 32'(done), 1);
      chk("en_score", 32'(score), 32'(m_score));
      en = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
